// File: rtl/serial_seq_pkg.sv
// Shared types and constants for the bit-serial register sequencer:
// FSM state encoding, route codes and the default register width.
package serial_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } seq_state_t;

  localparam logic [1:0] ROUTE_KEEP = 2'b00;
  localparam logic [1:0] ROUTE_A    = 2'b01;
  localparam logic [1:0] ROUTE_B    = 2'b10;
  localparam logic [1:0] ROUTE_SWAP = 2'b11;

endpackage

// File: rtl/serial_shift_reg.sv
// Operand register with parallel load and LSB-first right shift.
// Serial data enters at the MSB; Load takes priority over Shift.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Shift,
  input  logic [WIDTH-1:0] Din,
  input  logic             Sin,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (Load) begin
      q_d = Din;
    end else if (Shift) begin
      q_d = {Sin, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/serial_reg_sequencer.sv
// Register-and-control stage of the bit-serial processor: loads A/B, shifts them
// through the compute stage and routes results back. Optional SERIAL_SEQ_STEP_EN adds Step.
module serial_reg_sequencer
  import serial_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
`ifdef SERIAL_SEQ_STEP_EN
  input  logic             Step,
`endif
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic [1:0]       R,
  input  logic [WIDTH-1:0] Din,
  input  logic             A_Ret,
  input  logic             B_Ret,
  input  logic             F_A_B,
  output logic             A_Bit,
  output logic             B_Bit,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic load_a, load_b, shift_en, step_ok;
  logic n_a, n_b;

`ifdef SERIAL_SEQ_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  // Serial-in router: R is used live, so it must stay stable for the whole SHIFT
  always_comb begin
    n_a = A_Ret;
    n_b = B_Ret;
    case (R)
      ROUTE_KEEP: begin n_a = A_Ret; n_b = B_Ret; end
      ROUTE_A:    begin n_a = F_A_B; n_b = B_Ret; end
      ROUTE_B:    begin n_a = A_Ret; n_b = F_A_B; end
      ROUTE_SWAP: begin n_a = B_Ret; n_b = A_Ret; end
      default:    begin n_a = A_Ret; n_b = B_Ret; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        load_a = LoadA;
        load_b = LoadB;
        if (!(LoadA || LoadB) && Execute) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (step_ok) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = HOLD;
            done_d  = 1'b1;
          end
        end
      end
      // Wait for Execute to drop so a held level cannot retrigger
      HOLD: begin
        if (!Execute) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_reg_a (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (load_a),
    .Shift (shift_en),
    .Din   (Din),
    .Sin   (n_a),
    .Q     (A)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_reg_b (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (load_b),
    .Shift (shift_en),
    .Din   (Din),
    .Sin   (n_b),
    .Q     (B)
  );

  assign A_Bit = A[0];
  assign B_Bit = B[0];
  assign Busy  = (state_q == SHIFT);
  assign Done  = done_q;

endmodule

// File: tb/tb_serial_reg_sequencer.sv
// Directed bench for serial_reg_sequencer paired with a small behavioural compute stage.
// Step-mode case is included when SERIAL_SEQ_STEP_EN is defined.
module tb_serial_reg_sequencer;
  import serial_seq_pkg::*;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
`ifdef SERIAL_SEQ_STEP_EN
  logic         Step;
`endif
  logic         LoadA, LoadB, Execute;
  logic [1:0]   R;
  logic [W-1:0] Din;
  logic         A_Ret, B_Ret, F_A_B;
  logic         A_Bit, B_Bit;
  logic [W-1:0] A, B;
  logic         Busy, Done;
  logic [2:0]   fsel;

  int n_chk = 0;
  int n_bad = 0;
  int busy_cnt, done_cnt, done_idx, step_cnt;

  always #5 Clk = ~Clk;

  // Compute stage: returns the operand bits unchanged and a selected bitwise function
  assign A_Ret = A_Bit;
  assign B_Ret = B_Bit;
  always_comb begin
    case (fsel)
      3'b000:  F_A_B = A_Bit & B_Bit;
      3'b001:  F_A_B = A_Bit | B_Bit;
      3'b010:  F_A_B = A_Bit ^ B_Bit;
      default: F_A_B = ~A_Bit;
    endcase
  end

  serial_reg_sequencer #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
`ifdef SERIAL_SEQ_STEP_EN
    .Step    (Step),
`endif
    .LoadA   (LoadA),
    .LoadB   (LoadB),
    .Execute (Execute),
    .R       (R),
    .Din     (Din),
    .A_Ret   (A_Ret),
    .B_Ret   (B_Ret),
    .F_A_B   (F_A_B),
    .A_Bit   (A_Bit),
    .B_Bit   (B_Bit),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_ab(input logic [W-1:0] va, input logic [W-1:0] vb);
    LoadA = 1'b1; Din = va; tick();
    LoadA = 1'b0; LoadB = 1'b1; Din = vb; tick();
    LoadB = 1'b0;
  endtask

  // Pulse Execute for one edge, then observe Busy/Done for a bounded window
  task automatic run_pulse();
    Execute = 1'b1; tick();
    Execute = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_idx = -1;
    for (int i = 0; i < W + 6; i++) begin
      if (Busy) busy_cnt++;
      if (Done) begin done_cnt++; done_idx = i; end
      tick();
    end
  endtask

  initial begin
    Reset = 1'b1; LoadA = 1'b0; LoadB = 1'b0; Execute = 1'b0;
    R = ROUTE_KEEP; Din = '0; fsel = 3'b000;
`ifdef SERIAL_SEQ_STEP_EN
    Step = 1'b1;
`endif
    tick(); tick();
    chk("rst_A", 32'(A), 32'h0);
    chk("rst_B", 32'(B), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_abit", 32'(A_Bit), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    Reset = 1'b0;

    // AND into A
    load_ab(8'h33, 8'h55);
    chk("ld_A", 32'(A), 32'h33);
    chk("ld_B", 32'(B), 32'h55);
    chk("ld_abit", 32'(A_Bit), 32'h1);
    chk("ld_bbit", 32'(B_Bit), 32'h1);
    fsel = 3'b000; R = ROUTE_A;
    run_pulse();
    chk("and_busy", 32'(busy_cnt), 32'(W));
    chk("and_done", 32'(done_cnt), 32'h1);
    chk("and_done_at", 32'(done_idx), 32'(W));
    chk("and_A", 32'(A), 32'h11);
    chk("and_B", 32'(B), 32'h55);

    // Swap
    load_ab(8'h0F, 8'hF0);
    R = ROUTE_SWAP; fsel = 3'b011;
    run_pulse();
    chk("swp_A", 32'(A), 32'hF0);
    chk("swp_B", 32'(B), 32'h0F);
    chk("swp_abit", 32'(A_Bit), 32'h0);
    chk("swp_bbit", 32'(B_Bit), 32'h1);

    // Held Execute, XOR into B
    load_ab(8'hAA, 8'hFF);
    R = ROUTE_B; fsel = 3'b010;
    Execute = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
    end
    chk("hld_busy", 32'(busy_cnt), 32'(W));
    chk("hld_done", 32'(done_cnt), 32'h1);
    chk("hld_A", 32'(A), 32'hAA);
    chk("hld_B", 32'(B), 32'h55);
    chk("hld_state", 32'(dut.state_q), 32'(HOLD));
    Execute = 1'b0; tick(); tick();
    chk("hld_exit", 32'(dut.state_q), 32'(IDLE));

    // Reset three cycles into SHIFT
    load_ab(8'h0F, 8'hF0);
    R = ROUTE_SWAP;
    Execute = 1'b1; tick();
    Execute = 1'b0; tick(); tick(); tick();
    chk("mid_busy_pre", 32'(Busy), 32'h1);
    Reset = 1'b1; tick();
    chk("mid_A", 32'(A), 32'h0);
    chk("mid_B", 32'(B), 32'h0);
    chk("mid_busy", 32'(Busy), 32'h0);
    chk("mid_done", 32'(Done), 32'h0);
    chk("mid_state", 32'(dut.state_q), 32'(IDLE));
    Reset = 1'b0;

    // LoadA ignored while shifting
    load_ab(8'h33, 8'h55);
    R = ROUTE_A; fsel = 3'b000;
    Execute = 1'b1; tick();
    Execute = 1'b0; tick();
    LoadA = 1'b1; Din = 8'h77; tick();
    LoadA = 1'b0;
    for (int i = 0; i < W + 2; i++) tick();
    chk("lds_A", 32'(A), 32'h11);
    chk("lds_B", 32'(B), 32'h55);

    // LoadB with Execute in IDLE: load wins, no op
    LoadB = 1'b1; Din = 8'h3C; Execute = 1'b1; tick();
    LoadB = 1'b0; Execute = 1'b0;
    chk("ldx_B", 32'(B), 32'h3C);
    chk("ldx_busy", 32'(Busy), 32'h0);
    tick();
    chk("ldx_busy2", 32'(Busy), 32'h0);

`ifdef SERIAL_SEQ_STEP_EN
    // Step every third cycle: 8 steps span 24 busy cycles
    load_ab(8'h33, 8'h55);
    R = ROUTE_A; fsel = 3'b000; Step = 1'b0;
    Execute = 1'b1; tick();
    Execute = 1'b0;
    busy_cnt = 0; done_cnt = 0; step_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      Step = (i % 3 == 2);
      if (Busy) busy_cnt++;
      if (Busy && Step) step_cnt++;
      if (Done) done_cnt++;
      tick();
    end
    Step = 1'b1;
    chk("stp_busy", 32'(busy_cnt), 32'd24);
    chk("stp_steps", 32'(step_cnt), 32'(W));
    chk("stp_done", 32'(done_cnt), 32'h1);
    chk("stp_A", 32'(A), 32'h11);
    chk("stp_B", 32'(B), 32'h55);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
